// File: rtl/simple_rs_pkg.sv
// Shared types and field layout for the simple-ALU reservation station.
// A dispatched entry is {rs2_vt, rs2_rdy, rs1_vt, rs1_rdy, rd, alu_ctrl}, LSB first = alu_ctrl[0].
package simple_rs_pkg;
  localparam int TAG_W        = 5;
  localparam int ENT_W        = 76;
  localparam int ALU_CTRL_LSB = 0;
  localparam int RD_LSB       = 5;
  localparam int RS1_RDY      = 10;
  localparam int RS1_VT_LSB   = 11;
  localparam int RS2_RDY      = 43;
  localparam int RS2_VT_LSB   = 44;

  typedef struct packed {
    logic [31:0] rs2_vt;
    logic        rs2_rdy;
    logic [31:0] rs1_vt;
    logic        rs1_rdy;
    logic [4:0]  rd;
    logic [4:0]  alu_ctrl;
  } rs_ent_t;

  // Capture a CDB result into whichever operands are still waiting on that tag.
  function automatic rs_ent_t ent_wake(rs_ent_t e, logic vld, logic [TAG_W-1:0] tag,
                                       logic [31:0] val);
    rs_ent_t r;
    r = e;
    if (vld && !e.rs1_rdy && (e.rs1_vt[TAG_W-1:0] == tag)) begin
      r.rs1_vt  = val;
      r.rs1_rdy = 1'b1;
    end
    if (vld && !e.rs2_rdy && (e.rs2_vt[TAG_W-1:0] == tag)) begin
      r.rs2_vt  = val;
      r.rs2_rdy = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/rs_simple_entry.sv
// One reservation-station slot: occupancy bit, operand wakeup, optional CDB forward (RS_SIMPLE_FWD_EN).
// Latency: load/wakeup visible one cycle later (same cycle on the output when forwarding is enabled).
// Backpressure: none here; the parent only loads a free slot.
module rs_simple_entry
  import simple_rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  rs_ent_t          load_ent,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             issue,
  output logic             occ,
  output rs_ent_t          ent
);
  logic    occ_q, occ_d;
  rs_ent_t ent_q, ent_d;
  rs_ent_t ent_vis;

  always_comb begin
    occ_d = occ_q;
    ent_d = ent_q;
    if (occ_q) ent_d = ent_wake(ent_q, cdb_valid, cdb_tag, cdb_value);
    if (issue) occ_d = 1'b0;
    // Loads only target a free slot, so they cannot collide with a real issue.
    if (load) begin
      occ_d = 1'b1;
      ent_d = ent_wake(load_ent, cdb_valid, cdb_tag, cdb_value);
    end
    if (flush) occ_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 1'b0;
      ent_q <= '0;
    end else begin
      occ_q <= occ_d;
      ent_q <= ent_d;
    end
  end

`ifdef RS_SIMPLE_FWD_EN
  assign ent_vis = ent_wake(ent_q, cdb_valid, cdb_tag, cdb_value);
`else
  assign ent_vis = ent_q;
`endif

  assign occ = occ_q;
  assign ent = occ_q ? ent_vis : '0;
endmodule

// File: rtl/rs_simple.sv
// Two-entry reservation station for the simple ALU; optional CDB forwarding via RS_SIMPLE_FWD_EN.
// Latency: dispatch visible next cycle; issue clears the slot at the same edge.
// Backpressure: dispatch_ready drops when both slots are occupied (same-cycle issue does not help).
module rs_simple
  import simple_rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic [ENT_W-1:0] dispatch_entry,
  output logic             dispatch_ready,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             simple_0_issue,
  input  logic             simple_1_issue,
  output logic [ENT_W-1:0] rs_simple_0,
  output logic [ENT_W-1:0] rs_simple_1,
  output logic             selector,
  output logic [1:0]       occupancy
);
  logic       occ0, occ1;
  logic       accept, load0, load1;
  logic       nxt0, nxt1;
  logic       sel_q, sel_d;
  logic [1:0] occupancy_q, occupancy_d;
  rs_ent_t    ent0, ent1;

  assign dispatch_ready = !(occ0 && occ1);
  assign accept         = dispatch_valid && dispatch_ready;
  assign load0          = accept && !occ0;
  assign load1          = accept && occ0 && !occ1;

  rs_simple_entry u_ent0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .load(load0), .load_ent(dispatch_entry),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue(simple_0_issue), .occ(occ0), .ent(ent0)
  );

  rs_simple_entry u_ent1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .load(load1), .load_ent(dispatch_entry),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue(simple_1_issue), .occ(occ1), .ent(ent1)
  );

  // Age follows the post-edge occupancy: a lone survivor is oldest, a fresh load is youngest.
  always_comb begin
    nxt0  = load0 || (occ0 && !simple_0_issue);
    nxt1  = load1 || (occ1 && !simple_1_issue);
    sel_d = sel_q;
    if (!flush) begin
      if (nxt0 && !nxt1)      sel_d = 1'b1;
      else if (nxt1 && !nxt0) sel_d = 1'b0;
      else if (nxt0 && nxt1) begin
        if (load0)      sel_d = 1'b0;
        else if (load1) sel_d = 1'b1;
      end
    end
    occupancy_d = flush ? 2'd0 : ({1'b0, nxt0} + {1'b0, nxt1});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      sel_q       <= sel_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign rs_simple_0 = ent0;
  assign rs_simple_1 = ent1;
  assign selector    = sel_q;
  assign occupancy   = occupancy_q;

`ifndef SYNTHESIS
  a_issue0_rdy: assert property (@(posedge clk) disable iff (!rst_n)
    (simple_0_issue && occ0) |-> (rs_simple_0[RS1_RDY] && rs_simple_0[RS2_RDY]));
  a_issue1_rdy: assert property (@(posedge clk) disable iff (!rst_n)
    (simple_1_issue && occ1) |-> (rs_simple_1[RS1_RDY] && rs_simple_1[RS2_RDY]));
  a_single_issue: assert property (@(posedge clk) disable iff (!rst_n)
    !(simple_0_issue && simple_1_issue));
`endif
endmodule

// File: tb/tb_rs_simple.sv
// Directed vector table plus randomized traffic against an age-queue reference model.
module tb_rs_simple;
  import simple_rs_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             dispatch_valid;
  logic [ENT_W-1:0] dispatch_entry;
  logic             dispatch_ready;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             simple_0_issue;
  logic             simple_1_issue;
  logic [ENT_W-1:0] rs_simple_0;
  logic [ENT_W-1:0] rs_simple_1;
  logic             selector;
  logic [1:0]       occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rs_simple dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_entry(dispatch_entry),
    .dispatch_ready(dispatch_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .simple_0_issue(simple_0_issue), .simple_1_issue(simple_1_issue),
    .rs_simple_0(rs_simple_0), .rs_simple_1(rs_simple_1),
    .selector(selector), .occupancy(occupancy)
  );

  typedef struct {
    bit          fl;
    bit          dv;
    logic [75:0] de;
    bit          cv;
    logic [4:0]  ct;
    logic [31:0] cval;
    bit          i0;
    bit          i1;
    logic [75:0] e0;
    logic [75:0] e1;
    logic [1:0]  occ;
    bit          rdy;
    bit          sel;
  } vec_t;

  vec_t tbl[14];

  // model state
  rs_ent_t m_ent[2];
  bit      m_v[2];
  int      m_age[$];
  bit      m_sel;

  function automatic logic [75:0] mk(logic [31:0] r2, bit r2r, logic [31:0] r1, bit r1r,
                                     logic [4:0] rd, logic [4:0] op);
    return {r2, r2r, r1, r1r, rd, op};
  endfunction

  function automatic vec_t row(bit fl, bit dv, logic [75:0] de, bit cv, logic [4:0] ct,
                               logic [31:0] cval, bit i0, bit i1, logic [75:0] e0,
                               logic [75:0] e1, logic [1:0] occ, bit rdy, bit sel);
    vec_t v;
    v.fl = fl; v.dv = dv; v.de = de; v.cv = cv; v.ct = ct; v.cval = cval;
    v.i0 = i0; v.i1 = i1; v.e0 = e0; v.e1 = e1; v.occ = occ; v.rdy = rdy; v.sel = sel;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [75:0] e0, input logic [75:0] e1,
                         input logic [1:0] occ, input bit rdy, input bit sel);
    chk({nm, "_e0"}, rs_simple_0, e0);
    chk({nm, "_e1"}, rs_simple_1, e1);
    chk({nm, "_occ"}, {74'd0, occupancy}, {74'd0, occ});
    chk({nm, "_rdy"}, {75'd0, dispatch_ready}, {75'd0, rdy});
    chk({nm, "_sel"}, {75'd0, selector}, {75'd0, sel});
  endtask

  task automatic drive(input bit fl, input bit dv, input logic [75:0] de, input bit cv,
                       input logic [4:0] ct, input logic [31:0] cval, input bit i0, input bit i1);
    flush = fl; dispatch_valid = dv; dispatch_entry = de;
    cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
    simple_0_issue = i0; simple_1_issue = i1;
  endtask

  function automatic rs_ent_t woke(rs_ent_t e, bit v, logic [4:0] t, logic [31:0] val);
    rs_ent_t r = e;
    if (v && !e.rs1_rdy && e.rs1_vt[4:0] == t) begin r.rs1_vt = val; r.rs1_rdy = 1'b1; end
    if (v && !e.rs2_rdy && e.rs2_vt[4:0] == t) begin r.rs2_vt = val; r.rs2_rdy = 1'b1; end
    return r;
  endfunction

  function automatic void age_remove(int idx);
    int nq[$];
    foreach (m_age[k]) if (m_age[k] != idx) nq.push_back(m_age[k]);
    m_age = nq;
  endfunction

  initial begin
    logic [75:0] ea, eb, ebw, ec, ed, edw, ee, ef, efw, eg;
    ea  = mk(32'h5, 1, 32'h7, 1, 5'd3, 5'd0);
    eb  = mk(32'h4, 0, 32'h11, 1, 5'd6, 5'd2);
    ebw = mk(32'hABCD, 1, 32'h11, 1, 5'd6, 5'd2);
    ec  = mk(32'h1, 1, 32'h2, 1, 5'd7, 5'd7);
    ed  = mk(32'h22, 1, 32'h9, 0, 5'd1, 5'd4);
    edw = mk(32'h22, 1, 32'h1234, 1, 5'd1, 5'd4);
    ee  = mk(32'h33, 1, 32'h44, 1, 5'd2, 5'd5);
    ef  = mk(32'h2, 0, 32'h2, 0, 5'd8, 5'd6);
    efw = mk(32'h55, 1, 32'h55, 1, 5'd8, 5'd6);
    eg  = mk(32'h66, 1, 32'h77, 1, 5'd9, 5'd1);

    tbl[0]  = row(0, 1, ea, 0, 0, 0,          0, 0, ea,  0,   2'd1, 1, 1);
    tbl[1]  = row(0, 1, eb, 1, 4, 32'hABCD,   0, 0, ea,  ebw, 2'd2, 0, 1);
    tbl[2]  = row(0, 1, ec, 0, 0, 0,          0, 0, ea,  ebw, 2'd2, 0, 1);
    tbl[3]  = row(0, 0, 0,  0, 0, 0,          1, 0, 0,   ebw, 2'd1, 1, 0);
    tbl[4]  = row(0, 1, ed, 0, 0, 0,          0, 0, ed,  ebw, 2'd2, 0, 0);
    tbl[5]  = row(0, 0, 0,  1, 9, 32'h1234,   0, 0, edw, ebw, 2'd2, 0, 0);
    tbl[6]  = row(0, 0, 0,  0, 0, 0,          0, 1, edw, 0,   2'd1, 1, 1);
    tbl[7]  = row(0, 1, ee, 0, 0, 0,          0, 0, edw, ee,  2'd2, 0, 1);
    tbl[8]  = row(1, 1, ec, 1, 3, 32'h99,     0, 0, 0,   0,   2'd0, 1, 1);
    tbl[9]  = row(0, 0, 0,  0, 0, 0,          0, 0, 0,   0,   2'd0, 1, 1);
    tbl[10] = row(0, 0, 0,  0, 0, 0,          0, 1, 0,   0,   2'd0, 1, 1);
    tbl[11] = row(0, 1, ef, 1, 2, 32'h55,     0, 0, efw, 0,   2'd1, 1, 1);
    tbl[12] = row(0, 1, eg, 0, 0, 0,          1, 0, 0,   eg,  2'd1, 1, 0);
    tbl[13] = row(0, 0, 0,  0, 0, 0,          0, 1, 0,   0,   2'd0, 1, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 2'd0, 1, 0);
    rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].fl, tbl[r].dv, tbl[r].de, tbl[r].cv, tbl[r].ct, tbl[r].cval,
            tbl[r].i0, tbl[r].i1);
`ifdef RS_SIMPLE_FWD_EN
      if (r == 5) begin
        #1;
        chk("fwd_same_cycle_e0", rs_simple_0, edw);
      end
`endif
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", r), tbl[r].e0, tbl[r].e1, tbl[r].occ, tbl[r].rdy, tbl[r].sel);
    end

    // asynchronous reset in the middle of a cycle with a full station
    drive(0, 1, ea, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 1, ee, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_all("prefill", ea, ee, 2'd2, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 2'd0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    m_v[0] = 0; m_v[1] = 0; m_sel = 0; m_age.delete();
    m_ent[0] = '0; m_ent[1] = '0;
    for (int c = 0; c < 400; c++) begin
      bit          fl, dv, cv, i0, i1;
      rs_ent_t     de;
      logic [4:0]  ct;
      logic [31:0] cval;
      int          k, slot;
      logic [75:0] x0, x1;
      fl = ($urandom_range(0, 31) == 0);
      dv = ($urandom_range(0, 9) < 6);
      de.rs1_rdy = $urandom_range(0, 1);
      de.rs1_vt  = $urandom;
      if (!de.rs1_rdy) de.rs1_vt[4:0] = 5'($urandom_range(0, 7));
      de.rs2_rdy = $urandom_range(0, 1);
      de.rs2_vt  = $urandom;
      if (!de.rs2_rdy) de.rs2_vt[4:0] = 5'($urandom_range(0, 7));
      de.rd       = 5'($urandom);
      de.alu_ctrl = 5'($urandom);
      cv   = $urandom_range(0, 1);
      ct   = 5'($urandom_range(0, 7));
      cval = $urandom;
      i0 = 0; i1 = 0;
      if ($urandom_range(0, 9) < 5) begin
        k = $urandom_range(0, 1);
        if (!m_v[k] || (m_ent[k].rs1_rdy && m_ent[k].rs2_rdy)) begin
          if (k == 0) i0 = 1; else i1 = 1;
        end
      end
      drive(fl, dv, de, cv, ct, cval, i0, i1);
      @(posedge clk);
      #1;
      slot = -1;
      if (fl) begin
        m_v[0] = 0; m_v[1] = 0; m_age.delete();
      end else begin
        if (dv && !(m_v[0] && m_v[1])) slot = m_v[0] ? 1 : 0;
        for (int i = 0; i < 2; i++) if (m_v[i]) m_ent[i] = woke(m_ent[i], cv, ct, cval);
        if (i0 && m_v[0]) begin m_v[0] = 0; age_remove(0); end
        if (i1 && m_v[1]) begin m_v[1] = 0; age_remove(1); end
        if (slot >= 0) begin
          m_ent[slot] = woke(de, cv, ct, cval);
          m_v[slot]   = 1;
          m_age.push_back(slot);
        end
      end
      if (m_age.size() > 0) m_sel = (m_age[0] == 0);
      x0 = m_v[0] ? m_ent[0] : '0;
      x1 = m_v[1] ? m_ent[1] : '0;
      chk_all($sformatf("rnd%0d", c), x0, x1, 2'(m_v[0]) + 2'(m_v[1]),
              !(m_v[0] && m_v[1]), m_sel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rs_simple.md
Name: rs_simple

Overview:
- Two-entry reservation station feeding the "simple" ALU functional unit (ex_simple).
- Accepts one dispatched instruction per cycle from decode/rename.
- Holds operands until ready and captures results broadcast on the common data bus (CDB wakeup).
- Presents both entries to the FU and clears an entry when the FU signals it has issued.

Parameters:
- TAG_W, 5, producer tag width. Equals the Rd addr field of the FU's executed-instruction output.
- ENT_W, 76, entry width. Fixed format {rs2_vt[31:0], rs2_rdy, rs1_vt[31:0], rs1_rdy, rd[4:0], alu_ctrl[4:0]}, LSB = alu_ctrl[0].

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all entries (mispredict)
- dispatch_valid  in  1  dispatch request
- dispatch_entry  in  76  new entry. When an rdy bit = 0, vt[TAG_W-1:0] holds the producer tag and the upper bits are don't-care.
- dispatch_ready  out  1  at least one free entry
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  result tag
- cdb_value  in  32  result value
- simple_0_issue  in  1  FU consumed entry 0
- simple_1_issue  in  1  FU consumed entry 1
- rs_simple_0  out  76  entry 0 contents; all-zero when unoccupied
- rs_simple_1  out  76  entry 1 contents; all-zero when unoccupied
- selector  out  1  1 = entry 0 is older, 0 = entry 1 is older
- occupancy  out  2  number of occupied entries (0..2)

Behaviour:
- Reset (rst_n low, async): both entries invalid.
  - rs_simple_0 and rs_simple_1 = 0.
  - selector = 0, occupancy = 0, dispatch_ready = 1.
  - Deassertion is sampled synchronously.
  - Reset mid-operation discards all entries with no output pulses.
- Per-entry state: occ bit plus a 76-bit register. Outputs are registered entry contents gated by occ.
- Dispatch:
  - Accepted when dispatch_valid && dispatch_ready.
  - Allocates the lowest free index (entry 0 first).
  - Entry becomes visible on rs_simple_x the next cycle.
  - dispatch_ready = !(occ0 && occ1), computed from current state only. An issue in the same cycle does not free a slot for that cycle's dispatch.
- Wakeup:
  - Each cycle, for every occupied entry and for the incoming dispatch entry: if cdb_valid, rdy == 0 and vt[TAG_W-1:0] == cdb_tag, then vt <= cdb_value and rdy <= 1.
  - rs1 and rs2 are checked independently; both may wake in the same cycle.
  - Dispatch and matching broadcast in the same cycle: the entry is stored already ready.
- Issue:
  - simple_x_issue high at edge clears occ_x.
  - Issue on an unoccupied entry is ignored.
  - Issue beats a wakeup to the same entry in the same cycle.
- Age / selector:
  - Dispatch into an empty station: the new entry is oldest.
  - Dispatch while the other entry is occupied: the other entry is oldest.
  - Issue of the oldest with the other still occupied: the remaining entry becomes oldest.
  - selector holds its value when the station goes empty.
- Flush: clears both occ bits next edge. It overrides same-cycle dispatch, wakeup and issue.
- occupancy: registered, equals occ0 + occ1.
- Protocol assertions (sim only):
  - issue of an entry with rdy bits not both 1;
  - simple_0_issue && simple_1_issue in the same cycle (single-ALU FU).

Optional Feature:
- Macro RS_SIMPLE_FWD_EN.
- Defined:
  - rs_simple_x outputs combinationally forward a matching CDB broadcast (value substituted, rdy = 1) in the broadcast cycle.
  - The FU can issue the dependent instruction in the same cycle.
  - The register update is unchanged.
- Undefined: outputs reflect registered state only; the dependent instruction becomes issuable one cycle after the broadcast.

Decomposition:
- Package simple_rs_pkg:
  - ENT_W, TAG_W;
  - field offset constants: ALU_CTRL_LSB = 0, RD_LSB = 5, RS1_RDY = 10, RS1_VT_LSB = 11, RS2_RDY = 43, RS2_VT_LSB = 44;
  - entry struct typedef.
- Sub-module rs_simple_entry: one entry register with occ, the wakeup comparators and the optional forward mux. Instantiated twice; the top holds allocation, age and flush logic.

Test Plan:
- Reset then dispatch entry {rs2 rdy 5, rs1 rdy 7, rd = 3, op = 0} -> next cycle rs_simple_0 shows it, occupancy = 1, selector = 1, dispatch_ready = 1.
- Dispatch two entries back-to-back -> occupancy = 2, dispatch_ready = 0. Third dispatch_valid is not accepted; entry 0 and entry 1 contents are unchanged.
- Entry 0 with rs1 waiting on tag 9; cdb_valid, cdb_tag = 9, cdb_value = 0x1234 -> next cycle rs1_vt = 0x1234, rs1_rdy = 1. With RS_SIMPLE_FWD_EN, visible on rs_simple_0 in the same cycle.
- Dispatch with rs2 tag 4 while the CDB broadcasts tag 4, value 0xABCD -> stored entry has rs2_rdy = 1, rs2_vt = 0xABCD.
- Both entries full, entry 0 older; simple_0_issue -> entry 0 cleared, selector = 0. Dispatch next cycle goes to entry 0 and selector stays 0.
- Full station with flush asserted together with dispatch_valid and cdb_valid -> next cycle occupancy = 0 and both outputs = 0. Asserting rst_n = 0 mid-cycle clears the outputs immediately.
